rf_dump_reader: RTL and testbench
=================================

# rf_dump_reader

Read-side sequencer for the integer register file. On a start command it walks register numbers FIRST..LAST through one register-file read port. It captures each RDATA into an output register and streams (number, value) beats over a valid/ready interface to the debug/trace path. The block never writes the register file; it only drives the read-number input and consumes the combinational read data.

## Interface
- DW, 32, data width; must equal register-file width
- AW, 5, register-number width

- CLK  in  1  clock; all state updates on the rising edge
- RSTN  in  1  asynchronous active-low reset
- START  in  1  one-cycle command; ignored while BUSY
- FIRST  in  AW  first register number, sampled with START
- LAST  in  AW  last register number, inclusive, sampled with START
- ABORT  in  1  terminate the current dump; ignored when idle
- RD_NUM  out  AW  register number to the register-file read port, registered
- RD_DATA  in  DW  combinational read data for RD_NUM
- OUT_VALID  out  1  output beat valid
- OUT_READY  in  1  consumer accepts the beat
- OUT_NUM  out  AW  register number of the beat
- OUT_DATA  out  DW  captured register value
- BUSY  out  1  dump in progress, or beats still pending
- DONE  out  1  one-cycle pulse when the dump completes or aborts

## Operation
- States:
  - IDLE: waits for START.
  - READ: pointer valid, captures when the output register is free.
  - DRAIN: all registers read, last beat not yet accepted.
  - FIN: asserts DONE, returns to IDLE.
- IDLE → READ: START=1 and FIRST ≤ LAST (unsigned). PTR ← FIRST, END ← LAST.
- IDLE → FIN: START=1 and FIRST > LAST. No beats are produced.
- Capture happens in READ when OUT_VALID=0 or OUT_READY=1:
  - OUT_NUM ← PTR, OUT_DATA ← RD_DATA, OUT_VALID ← 1.
  - If PTR == END, go to DRAIN; otherwise PTR ← PTR+1.
- Pointer increment is AW-bit. Wrap-around cannot occur because END ≤ 31 and the comparison is made before incrementing.
- In READ, if OUT_READY=1 and no capture is pending, OUT_VALID ← 0.
- DRAIN: on OUT_VALID & OUT_READY, OUT_VALID ← 0 and go to FIN.
- FIN: DONE=1 for exactly one cycle, then IDLE.
- ABORT=1 in READ or DRAIN: OUT_VALID ← 0 immediately, a pending beat is discarded, go to FIN. ABORT has priority over capture.
- Register 0 may be requested. The register file returns 0 for it and the block forwards that value unchanged.
- RD_NUM = PTR at all times. In IDLE it holds its last value.
- OUT_NUM and OUT_DATA hold stable while OUT_VALID=1 and OUT_READY=0.
- BUSY = (state ≠ IDLE).

## Timing
- Reset values: state IDLE, PTR 0, RD_NUM 0, OUT_VALID 0, OUT_NUM 0, OUT_DATA 0, BUSY 0, DONE 0.
- START sampled at edge E0 → RD_NUM=FIRST and BUSY=1 after E0.
- First capture at E1 → OUT_VALID=1 after E1.
- With OUT_READY held high, one beat is accepted per cycle.
- An N-register dump with OUT_READY=1 throughout:
  - last beat accepted at edge E(N+1)
  - DONE high during cycle E(N+1)..E(N+2)
  - BUSY low after E(N+2)
- Snapshot is per-register, not atomic. A write to register k at the same edge as its capture yields the old value, because the write lands at that edge.
- Back-pressure: capture stalls while OUT_VALID=1 and OUT_READY=0. PTR and RD_NUM do not advance.
- FIRST > LAST: DONE pulses the cycle after START, with zero beats and BUSY high for one cycle.
- Async reset mid-dump: all outputs return to reset values immediately, with no DONE pulse.

## Test plan
- Full dump, ready high: preload x1..x31 = 0x100+n, START with FIRST=1, LAST=31.
  - Expect 31 beats, OUT_NUM 1..31 with data 0x101..0x11F on consecutive cycles.
  - DONE one cycle after the last beat; BUSY low the following cycle.
- Back-pressure: FIRST=5, LAST=8, OUT_READY toggling 1,0,0,1,…
  - Expect exactly 4 beats (5..8) with no duplicates or drops.
  - Data stays stable during stalls; RD_NUM frozen while stalled.
- Register 0 and single register: FIRST=LAST=0 → one beat with OUT_NUM=0, OUT_DATA=0, then DONE.
  - FIRST=LAST=31 → one beat with the x31 value.
- Empty range: FIRST=10, LAST=3 → no OUT_VALID; DONE pulses one cycle after START.
  - A START pulsed while BUSY is ignored.
- Abort: FIRST=1, LAST=31, OUT_READY=1, ABORT asserted after the 6th beat.
  - OUT_VALID drops the next cycle, DONE pulses once, state returns to IDLE.
  - A new START then dumps normally.
- Concurrent write and reset:
  - Write x7=0xDEADBEEF at the capture edge of x7 → beat shows the old value.
  - Rerun with RSTN low mid-dump → outputs zero immediately, no DONE.

Source files
------------

// File: rtl/rf_dump_reader.sv
// Register-file dump sequencer: walks register numbers first..last through one read
// port and streams (number, value) beats over a valid/ready interface.
module rf_dump_reader #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [AW-1:0] first_i,
  input  logic [AW-1:0] last_i,
  input  logic          abort_i,
  output logic [AW-1:0] rd_num_o,
  input  logic [DW-1:0] rd_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [AW-1:0] out_num_o,
  output logic [DW-1:0] out_data_o,
  output logic          busy_o,
  output logic          done_o
);

  // state | meaning: IDLE wait start | READ capture when output free | DRAIN last beat pending | FIN done pulse
  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] end_q, end_d;
  logic [AW-1:0] out_num_q, out_num_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    out_num_d   = out_num_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (first_i <= last_i) begin
            ptr_d   = first_i;
            end_d   = last_i;
            state_d = S_READ;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_READ: begin
        // Abort wins over a capture in the same cycle; any pending beat is dropped.
        if (abort_i) begin
          out_valid_d = 1'b0;
          state_d     = S_FIN;
        end else if (!out_valid_q || out_ready_i) begin
          out_num_d   = ptr_q;
          out_data_d  = rd_data_i;
          out_valid_d = 1'b1;
          if (ptr_q == end_q) begin
            state_d = S_DRAIN;
          end else begin
            ptr_d = ptr_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end
      end
      S_DRAIN: begin
        if (abort_i || (out_valid_q && out_ready_i)) begin
          out_valid_d = 1'b0;
          state_d     = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      end_q       <= '0;
      out_num_q   <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      end_q       <= end_d;
      out_num_q   <= out_num_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign rd_num_o    = ptr_q;
  assign out_valid_o = out_valid_q;
  assign out_num_o   = out_num_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_FIN);

endmodule

// File: tb/tb_rf_dump_reader.sv
// Self-checking bench for rf_dump_reader: a behavioural register file plus an
// expected-beat queue built from the requested range.
module tb_rf_dump_reader;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] first = '0;
  logic [AW-1:0] last = '0;
  logic [AW-1:0] rd_num, out_num;
  logic [DW-1:0] rd_data, out_data;
  logic          out_valid, busy, done;

  logic [DW-1:0] mem [32];
  logic [DW-1:0] img [32];
  logic          load_en = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;

  int checks = 0;
  int errors = 0;

  rf_dump_reader #(.DW(DW), .AW(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .first_i(first), .last_i(last),
    .abort_i(abort), .rd_num_o(rd_num), .rd_data_i(rd_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_num_o(out_num), .out_data_o(out_data),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  // Register file: writes land at the rising edge, reads are combinational, x0 reads 0.
  always @(posedge clk) begin
    if (load_en) mem <= img;
    else if (wr_en) mem[wr_addr] <= wr_data;
  end
  assign rd_data = (rd_num == '0) ? '0 : mem[rd_num];

  task automatic load_mem();
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic fill_incr();
    for (int n = 0; n < 32; n++) img[n] = 32'h100 + n;
    load_mem();
  endtask

  task automatic fill_rand();
    for (int n = 0; n < 32; n++) img[n] = $urandom;
    load_mem();
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random ready.
  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode,
                          input int abort_after, input bit poke_start, input int wr_at);
    int            exp_num[$];
    logic [DW-1:0] exp_data[$];
    int            nexp, beats, done_cnt, cyc, done_cyc, last_acc, abort_cyc, end_cyc;
    bit            prev_stall, any_valid, aborted, wr_fired;
    logic [AW-1:0] pnum, prd;
    logic [DW-1:0] pdata;
    beats = 0; done_cnt = 0; cyc = 0; done_cyc = -1; last_acc = -1; abort_cyc = -1;
    end_cyc = -1; prev_stall = 0; any_valid = 0; aborted = 0; wr_fired = 0;
    pnum = '0; prd = '0; pdata = '0;
    for (int n = int'(f); n <= int'(l); n++) begin
      exp_num.push_back(n);
      exp_data.push_back((n == 0) ? '0 : img[n]);
    end
    nexp = exp_num.size();

    @(negedge clk);
    start = 1'b1; first = f; last = l; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b expected 1", busy);
    end
    if (nexp > 0) begin
      checks++;
      if (rd_num !== f) begin
        errors++; $display("FAIL rd_num_after_start: got %0d expected %0d", rd_num, f);
      end
    end

    while (cyc < 300) begin
      wr_en = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy === 1'b0 && done_cyc >= 0) begin
        end_cyc = cyc;
        break;
      end
      if (out_valid === 1'b1) any_valid = 1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_num !== pnum || out_data !== pdata || rd_num !== prd) begin
          errors++;
          $display("FAIL stall_hold: got v=%b num=%0d data=%h rd=%0d expected v=1 num=%0d data=%h rd=%0d",
                   out_valid, out_num, out_data, rd_num, pnum, pdata, prd);
        end
      end
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        checks++;
        if (out_valid !== 1'b0 || done !== 1'b1) begin
          errors++; $display("FAIL abort_response: got valid=%b done=%b expected valid=0 done=1", out_valid, done);
        end
      end
      if (abort_after > 0 && beats == abort_after && !aborted) begin
        abort = 1'b1; aborted = 1; abort_cyc = cyc; prev_stall = 0; out_ready = 1'b1;
      end else begin
        abort = 1'b0;
        case (mode)
          0: out_ready = 1'b1;
          1: out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        if (out_valid === 1'b1 && out_ready) begin
          checks++;
          if (exp_num.size() == 0) begin
            errors++; $display("FAIL extra_beat: got num=%0d data=%h expected no beat", out_num, out_data);
          end else begin
            if (out_num !== exp_num[0][AW-1:0] || out_data !== exp_data[0]) begin
              errors++;
              $display("FAIL beat: got num=%0d data=%h expected num=%0d data=%h",
                       out_num, out_data, exp_num[0], exp_data[0]);
            end
            void'(exp_num.pop_front());
            void'(exp_data.pop_front());
          end
          beats++;
          last_acc = cyc + 1;
        end
        prev_stall = (out_valid === 1'b1) && !out_ready;
        pnum = out_num; pdata = out_data; prd = rd_num;
      end
      if (wr_at >= 0 && !wr_fired && !aborted && busy === 1'b1 && out_ready &&
          rd_num == wr_at[AW-1:0] && out_valid === 1'b1) begin
        wr_en = 1'b1; wr_addr = wr_at[AW-1:0]; wr_data = 32'hDEADBEEF; wr_fired = 1;
      end
      if (poke_start && cyc == 2) begin
        start = 1'b1; first = 5'd20; last = 5'd25;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    abort = 1'b0; start = 1'b0; wr_en = 1'b0;

    checks++;
    if (end_cyc < 0) begin
      errors++; $display("FAIL timeout: got busy=%b after %0d cycles expected idle", busy, cyc);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL done_count: got %0d expected 1", done_cnt);
    end
    checks++;
    if (end_cyc != done_cyc + 1) begin
      errors++; $display("FAIL busy_after_done: got idle at %0d expected %0d", end_cyc, done_cyc + 1);
    end
    if (abort_after > 0) begin
      checks++;
      if (beats != abort_after) begin
        errors++; $display("FAIL abort_beats: got %0d expected %0d", beats, abort_after);
      end
    end else begin
      checks++;
      if (beats != nexp) begin
        errors++; $display("FAIL beat_count: got %0d expected %0d", beats, nexp);
      end
      if (nexp == 0) begin
        checks++;
        if (any_valid || done_cyc != 0) begin
          errors++; $display("FAIL empty_range: got valid_seen=%b done_at=%0d expected 0 and 0", any_valid, done_cyc);
        end
      end else begin
        checks++;
        if (done_cyc != last_acc) begin
          errors++; $display("FAIL done_timing: got %0d expected %0d", done_cyc, last_acc);
        end
        if (mode == 0) begin
          checks++;
          if (last_acc != nexp + 1) begin
            errors++; $display("FAIL full_rate: got last accept at %0d expected %0d", last_acc, nexp + 1);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0 || out_num !== '0 || out_data !== '0 || rd_num !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got v=%b num=%0d data=%h rd=%0d busy=%b done=%b expected all 0",
               out_valid, out_num, out_data, rd_num, busy, done);
    end
  endtask

  task automatic test_full_dump();
    fill_incr();
    run_dump(5'd1, 5'd31, 0, 0, 0, -1);
  endtask

  task automatic test_back_pressure();
    run_dump(5'd5, 5'd8, 1, 0, 0, -1);
  endtask

  task automatic test_single();
    run_dump(5'd0, 5'd0, 0, 0, 0, -1);
    run_dump(5'd31, 5'd31, 0, 0, 0, -1);
  endtask

  task automatic test_empty();
    run_dump(5'd10, 5'd3, 0, 0, 0, -1);
    run_dump(5'd2, 5'd6, 0, 0, 1, -1);
  endtask

  task automatic test_abort();
    run_dump(5'd1, 5'd31, 0, 6, 0, -1);
    run_dump(5'd3, 5'd9, 0, 0, 0, -1);
  endtask

  task automatic test_concurrent_write();
    fill_incr();
    run_dump(5'd1, 5'd31, 0, 0, 0, 7);
    img[7] = 32'hDEADBEEF;
    run_dump(5'd7, 5'd7, 0, 0, 0, -1);
  endtask

  task automatic test_async_reset();
    int dn;
    dn = 0;
    fill_incr();
    @(negedge clk);
    start = 1'b1; first = 5'd1; last = 5'd31; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_num !== '0 || out_data !== '0 || rd_num !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got v=%b num=%0d data=%h rd=%0d busy=%b done=%b expected all 0",
               out_valid, out_num, out_data, rd_num, busy, done);
    end
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) dn++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dn++;
    end
    checks++;
    if (dn != 0) begin
      errors++; $display("FAIL reset_no_done: got %0d done/busy cycles expected 0", dn);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a, b;
    for (int i = 0; i < 6; i++) begin
      fill_rand();
      a = 5'($urandom_range(0, 31));
      b = 5'($urandom_range(0, 31));
      if (a > b) begin
        logic [AW-1:0] t;
        t = a; a = b; b = t;
      end
      run_dump(a, b, 2, 0, 0, -1);
    end
    run_dump(5'd0, 5'd20, 2, 3, 0, -1);
  endtask

  initial begin
    for (int n = 0; n < 32; n++) img[n] = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_full_dump();
    test_back_pressure();
    test_single();
    test_empty();
    test_abort();
    test_concurrent_write();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
